spi_flash_boot_loader: RTL and testbench

//  APB master sitting directly upstream of the APB SPI master peripheral: on a start pulse it

---
 rtl/spi_flash_boot_loader.sv | 183 ++++++++++++++++++
 tb/tb_spi_flash_boot_loader.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_boot_loader.sv
// APB master that programs the SPI peripheral for a 0x03 flash read, drains the RX FIFO
// and streams each word into a memory write port (boot image copy into SRAM).
module spi_flash_boot_loader #(
  parameter int                        APB_ADDR_WIDTH = 12,
  parameter int                        MEM_ADDR_WIDTH = 16,
  parameter logic [7:0]                CLK_DIV        = 8'd4,
  parameter logic [APB_ADDR_WIDTH-1:0] OFS_STATUS     = 'h000,
  parameter logic [APB_ADDR_WIDTH-1:0] OFS_CLKDIV     = 'h004,
  parameter logic [APB_ADDR_WIDTH-1:0] OFS_CTRL       = 'h008,
  parameter logic [APB_ADDR_WIDTH-1:0] OFS_CMD        = 'h00C,
  parameter logic [APB_ADDR_WIDTH-1:0] OFS_ADDR       = 'h010,
  parameter logic [APB_ADDR_WIDTH-1:0] OFS_LEN        = 'h014,
  parameter logic [APB_ADDR_WIDTH-1:0] OFS_RXFIFO     = 'h020
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      start_i,
  input  logic [23:0]               flash_addr_i,
  input  logic [10:0]               word_cnt_i,
  input  logic [MEM_ADDR_WIDTH-1:0] dst_addr_i,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  input  logic                      eot_i,
  output logic                      mem_req_o,
  input  logic                      mem_gnt_i,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]               mem_wdata_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o
);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_CFG_CLKDIV = 4'd1;
  localparam logic [3:0] S_CFG_CMD    = 4'd2;
  localparam logic [3:0] S_CFG_ADDR   = 4'd3;
  localparam logic [3:0] S_CFG_LEN    = 4'd4;
  localparam logic [3:0] S_TRIG       = 4'd5;
  localparam logic [3:0] S_POLL       = 4'd6;
  localparam logic [3:0] S_POP        = 4'd7;
  localparam logic [3:0] S_MEMWR      = 4'd8;
  localparam logic [3:0] S_WAIT_EOT   = 4'd9;
  localparam logic [3:0] S_DONE       = 4'd10;

  logic [3:0]                state;
  logic [23:0]               flash_addr;
  logic [10:0]               word_cnt;
  logic [10:0]               word_idx;
  logic                      eot_armed;
  logic                      eot_seen;
  logic [15:0]               data_len;
  logic [APB_ADDR_WIDTH-1:0] req_addr;
  logic [31:0]               req_wdata;
  logic                      req_write;

  assign data_len = {word_cnt, 5'b00000};

  // Address/data/direction of the APB access that belongs to the current state.
  always_comb begin
    req_addr  = OFS_STATUS;
    req_wdata = 32'h0;
    req_write = 1'b0;
    case (state)
      S_CFG_CLKDIV: begin req_addr = OFS_CLKDIV; req_wdata = {24'h0, CLK_DIV};       req_write = 1'b1; end
      S_CFG_CMD:    begin req_addr = OFS_CMD;    req_wdata = {8'h03, 24'h0};         req_write = 1'b1; end
      S_CFG_ADDR:   begin req_addr = OFS_ADDR;   req_wdata = {flash_addr, 8'h00};    req_write = 1'b1; end
      S_CFG_LEN:    begin req_addr = OFS_LEN;
                          req_wdata = {data_len, 2'b00, 6'd24, 2'b00, 6'd8};       req_write = 1'b1; end
      S_TRIG:       begin req_addr = OFS_CTRL;   req_wdata = 32'h0000_0101;          req_write = 1'b1; end
      S_POP:        begin req_addr = OFS_RXFIFO; end
      default:      ;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state       <= S_IDLE;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= 32'h0;
      mem_req_o   <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= 32'h0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      flash_addr  <= 24'h0;
      word_cnt    <= 11'd0;
      word_idx    <= 11'd0;
      eot_armed   <= 1'b0;
      eot_seen    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      if (eot_armed && eot_i) eot_seen <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            if (word_cnt_i == 11'd0) begin
              done_o <= 1'b1;
            end else begin
              flash_addr <= flash_addr_i;
              word_cnt   <= word_cnt_i;
              word_idx   <= 11'd0;
              mem_addr_o <= dst_addr_i;
              busy_o     <= 1'b1;
              eot_armed  <= 1'b0;
              eot_seen   <= 1'b0;
              state      <= S_CFG_CLKDIV;
            end
          end
        end
        // Each access: one idle cycle (PSEL low), SETUP, then ACCESS until PREADY.
        S_CFG_CLKDIV, S_CFG_CMD, S_CFG_ADDR, S_CFG_LEN, S_TRIG, S_POLL, S_POP: begin
          if (!PSEL) begin
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            PADDR   <= req_addr;
            PWDATA  <= req_wdata;
            PWRITE  <= req_write;
          end else if (!PENABLE) begin
            PENABLE <= 1'b1;
          end else if (PREADY) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            if (PSLVERR) begin
              err_o     <= 1'b1;
              busy_o    <= 1'b0;
              eot_armed <= 1'b0;
              state     <= S_IDLE;
            end else begin
              case (state)
                S_CFG_CLKDIV: state <= S_CFG_CMD;
                S_CFG_CMD:    state <= S_CFG_ADDR;
                S_CFG_ADDR:   state <= S_CFG_LEN;
                S_CFG_LEN:    state <= S_TRIG;
                S_TRIG: begin
                  eot_armed <= 1'b1;
                  state     <= S_POLL;
                end
                S_POLL: if (PRDATA[23:16] != 8'd0) state <= S_POP;
                S_POP: begin
                  mem_wdata_o <= PRDATA;
                  mem_req_o   <= 1'b1;
                  state       <= S_MEMWR;
                end
                default: state <= S_IDLE;
              endcase
            end
          end
        end
        S_MEMWR: begin
          if (mem_gnt_i) begin
            mem_req_o  <= 1'b0;
            mem_addr_o <= mem_addr_o + MEM_ADDR_WIDTH'(4);
            word_idx   <= word_idx + 11'd1;
            state      <= (word_idx + 11'd1 == word_cnt) ? S_WAIT_EOT : S_POLL;
          end
        end
        // eot_i may already have fired while words were still being drained.
        S_WAIT_EOT: begin
          if (eot_seen || eot_i) begin
            done_o    <= 1'b1;
            busy_o    <= 1'b0;
            eot_armed <= 1'b0;
            state     <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_boot_loader.sv
// Directed testbench for spi_flash_boot_loader: APB slave / memory responders plus a
// negedge monitor that logs APB completions and memory writes for per-test checking.
module tb_spi_flash_boot_loader;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        start_i = 1'b0;
  logic [23:0] flash_addr_i = 24'h0;
  logic [10:0] word_cnt_i = 11'd0;
  logic [15:0] dst_addr_i = 16'h0;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PRDATA = 32'h0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;
  logic        eot_i = 1'b0;
  logic        mem_req_o;
  logic        mem_gnt_i = 1'b0;
  logic [15:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        busy_o, done_o, err_o;

  always #5 HCLK = ~HCLK;

  spi_flash_boot_loader dut (
    .HCLK(HCLK), .HRESET(HRESET), .start_i(start_i), .flash_addr_i(flash_addr_i),
    .word_cnt_i(word_cnt_i), .dst_addr_i(dst_addr_i), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .eot_i(eot_i), .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o)
  );

  int checks = 0;
  int errors = 0;

  logic [44:0] apb_log[$];
  logic [15:0] mem_a[$];
  logic [31:0] mem_d[$];
  int done_cnt = 0, err_cnt = 0, proto_viol = 0, stall_cycles = 0, mem_wait_cycles = 0;
  int status_reads = 0, rx_idx = 0, acc_stall = 0;
  int stall_cfg = 0, zero_polls = 0, mem_stall_word = -1, mem_stall_left = 0;
  bit err_en = 0;
  logic [11:0] err_addr = 12'h0;
  bit eot_pending = 0;
  bit prev_complete = 0, prev_mwait = 0;
  logic [44:0] setup_cap = '0;
  logic [15:0] prev_ma = 16'h0;
  logic [31:0] prev_md = 32'h0;

  logic [44:0] exp_cfg [5] = '{
    {1'b1, 12'h004, 32'h0000_0004},
    {1'b1, 12'h00C, 32'h0300_0000},
    {1'b1, 12'h010, 32'h0010_0000},
    {1'b1, 12'h014, 32'h0080_1808},
    {1'b1, 12'h008, 32'h0000_0101}
  };

  // SPI peripheral and memory responders, updated just after each rising edge.
  always @(posedge HCLK) begin
    #1;
    eot_i = eot_pending;
    eot_pending = 0;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h0;
    if (PSEL && PENABLE) begin
      if (acc_stall < stall_cfg) acc_stall++;
      else begin
        PREADY  = 1'b1;
        PSLVERR = err_en && PWRITE && (PADDR == err_addr);
        if (PADDR == 12'h000) PRDATA = (zero_polls > 0) ? 32'h0 : 32'h0001_0000;
        else if (PADDR == 12'h020) PRDATA = 32'hA500_0000 + 32'(rx_idx);
      end
    end else acc_stall = 0;
    mem_gnt_i = 1'b0;
    if (mem_req_o) begin
      if (mem_a.size() == mem_stall_word && mem_stall_left > 0) mem_stall_left--;
      else mem_gnt_i = 1'b1;
    end
  end

  // Monitor: logs completed transfers and counts protocol violations.
  always @(negedge HCLK) begin
    if (!HRESET) begin
      if (prev_complete && PSEL) proto_viol++;
      if (PENABLE && !PSEL) proto_viol++;
      if (PSEL && mem_req_o) proto_viol++;
      if (PSEL && !PENABLE) setup_cap = {PWRITE, PADDR, PWDATA};
      if (PSEL && PENABLE && setup_cap !== {PWRITE, PADDR, PWDATA}) proto_viol++;
      if (PSEL && PENABLE && !PREADY) stall_cycles++;
      prev_complete = PSEL && PENABLE && PREADY;
      if (prev_complete) begin
        apb_log.push_back({PWRITE, PADDR, PWDATA});
        if (!PWRITE && PADDR == 12'h000) begin
          status_reads++;
          if (zero_polls > 0) zero_polls--;
        end
        if (!PWRITE && PADDR == 12'h020) rx_idx++;
        if (PWRITE && PADDR == 12'h008) eot_pending = 1;
      end
      if (prev_mwait && !(mem_req_o && mem_addr_o == prev_ma && mem_wdata_o == prev_md)) proto_viol++;
      prev_mwait = mem_req_o && !mem_gnt_i;
      prev_ma = mem_addr_o;
      prev_md = mem_wdata_o;
      if (prev_mwait) mem_wait_cycles++;
      if (mem_req_o && mem_gnt_i) begin
        mem_a.push_back(mem_addr_o);
        mem_d.push_back(mem_wdata_o);
      end
      if (done_o) done_cnt++;
      if (err_o) err_cnt++;
      if ((done_o || err_o) && busy_o) proto_viol++;
    end else begin
      prev_complete = 0;
      prev_mwait = 0;
    end
  end

  task automatic clear_logs();
    apb_log.delete(); mem_a.delete(); mem_d.delete();
    done_cnt = 0; err_cnt = 0; proto_viol = 0; stall_cycles = 0; mem_wait_cycles = 0;
    status_reads = 0; rx_idx = 0;
  endtask

  task automatic run_copy(input logic [23:0] fa, input logic [10:0] cnt, input logic [15:0] dst,
                          input bit pulse_again, output bit busy_seen, output bit timed_out);
    int cyc = 0;
    timed_out = 0;
    @(negedge HCLK);
    flash_addr_i = fa; word_cnt_i = cnt; dst_addr_i = dst; start_i = 1'b1;
    @(negedge HCLK);
    start_i = 1'b0;
    busy_seen = busy_o;
    while (done_cnt == 0 && err_cnt == 0) begin
      if (cyc >= 3000) begin timed_out = 1; break; end
      if (pulse_again && cyc == 10) begin
        flash_addr_i = 24'hFFFFFF; word_cnt_i = 11'd7; dst_addr_i = 16'h3000; start_i = 1'b1;
      end else start_i = 1'b0;
      @(negedge HCLK);
      cyc++;
    end
    start_i = 1'b0;
    repeat (5) @(negedge HCLK);
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    repeat (3) @(negedge HCLK);
    checks++;
    if ({PSEL, PENABLE, PWRITE, mem_req_o, busy_o, done_o, err_o} !== 7'b0) begin
      errors++; $display("[TB] FAIL reset_ctrl: got %b expected 0000000",
                         {PSEL, PENABLE, PWRITE, mem_req_o, busy_o, done_o, err_o});
    end
    checks++;
    if ({PADDR, PWDATA, mem_addr_o, mem_wdata_o} !== 92'h0) begin
      errors++; $display("[TB] FAIL reset_data: got %h expected 0",
                         {PADDR, PWDATA, mem_addr_o, mem_wdata_o});
    end
    HRESET = 1'b0;
    @(negedge HCLK);
  endtask

  task automatic test_basic();
    bit b, to;
    clear_logs();
    run_copy(24'h001000, 11'd4, 16'h0100, 0, b, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL basic_timeout: got timeout expected done"); end
    checks++; if (b !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy: got %b expected 1", b); end
    checks++; if (done_cnt != 1 || err_cnt != 0) begin
      errors++; $display("[TB] FAIL basic_done: got done=%0d err=%0d expected 1/0", done_cnt, err_cnt); end
    checks++; if (apb_log.size() != 13) begin
      errors++; $display("[TB] FAIL basic_apb_count: got %0d expected 13", apb_log.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (apb_log[i] !== exp_cfg[i]) begin
        errors++; $display("[TB] FAIL basic_cfg%0d: got %h expected %h", i, apb_log[i], exp_cfg[i]); end
    end
    checks++; if (mem_a.size() != 4) begin
      errors++; $display("[TB] FAIL basic_mem_count: got %0d expected 4", mem_a.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem_a[i] !== 16'h0100 + 16'(4 * i) || mem_d[i] !== 32'hA500_0000 + 32'(i)) begin
        errors++; $display("[TB] FAIL basic_mem%0d: got %h/%h expected %h/%h", i, mem_a[i], mem_d[i],
                           16'h0100 + 16'(4 * i), 32'hA500_0000 + 32'(i)); end
    end
    checks++; if (proto_viol != 0) begin
      errors++; $display("[TB] FAIL basic_protocol: got %0d violations expected 0", proto_viol); end
  endtask

  task automatic test_apb_stall();
    bit b, to;
    stall_cfg = 3;
    clear_logs();
    run_copy(24'h001000, 11'd4, 16'h0100, 0, b, to);
    stall_cfg = 0;
    checks++; if (to || done_cnt != 1) begin
      errors++; $display("[TB] FAIL stall_done: got done=%0d timeout=%0b expected 1/0", done_cnt, to); end
    checks++; if (stall_cycles != 39) begin
      errors++; $display("[TB] FAIL stall_cycles: got %0d expected 39", stall_cycles); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (apb_log[i] !== exp_cfg[i]) begin
        errors++; $display("[TB] FAIL stall_cfg%0d: got %h expected %h", i, apb_log[i], exp_cfg[i]); end
    end
    checks++; if (mem_a.size() != 4 || mem_a[3] !== 16'h010C || mem_d[3] !== 32'hA500_0003) begin
      errors++; $display("[TB] FAIL stall_mem: got n=%0d last=%h/%h expected 4 010c/a5000003",
                         mem_a.size(), mem_a[3], mem_d[3]); end
    checks++; if (proto_viol != 0) begin
      errors++; $display("[TB] FAIL stall_protocol: got %0d violations expected 0", proto_viol); end
  endtask

  task automatic test_status_poll();
    bit b, to, early_pop;
    zero_polls = 5;
    clear_logs();
    run_copy(24'h002000, 11'd2, 16'h0400, 0, b, to);
    checks++; if (to || done_cnt != 1) begin
      errors++; $display("[TB] FAIL poll_done: got done=%0d timeout=%0b expected 1/0", done_cnt, to); end
    checks++; if (status_reads != 7 || apb_log.size() != 14) begin
      errors++; $display("[TB] FAIL poll_count: got %0d polls/%0d accesses expected 7/14",
                         status_reads, apb_log.size()); end
    early_pop = 0;
    for (int i = 5; i <= 10; i++) if (apb_log[i][43:32] !== 12'h000) early_pop = 1;
    checks++; if (early_pop || apb_log[11][43:32] !== 12'h020) begin
      errors++; $display("[TB] FAIL poll_order: got early=%0b idx11=%h expected 0/020",
                         early_pop, apb_log[11][43:32]); end
    checks++; if (mem_a.size() != 2 || mem_a[1] !== 16'h0404 || mem_d[1] !== 32'hA500_0001) begin
      errors++; $display("[TB] FAIL poll_mem: got n=%0d %h/%h expected 2 0404/a5000001",
                         mem_a.size(), mem_a[1], mem_d[1]); end
  endtask

  task automatic test_mem_stall();
    bit b, to;
    mem_stall_word = 2;
    mem_stall_left = 4;
    clear_logs();
    run_copy(24'h001000, 11'd4, 16'h0100, 0, b, to);
    mem_stall_word = -1;
    checks++; if (to || done_cnt != 1) begin
      errors++; $display("[TB] FAIL memstall_done: got done=%0d timeout=%0b expected 1/0", done_cnt, to); end
    checks++; if (mem_wait_cycles != 4) begin
      errors++; $display("[TB] FAIL memstall_wait: got %0d expected 4", mem_wait_cycles); end
    checks++; if (mem_a.size() != 4 || mem_a[2] !== 16'h0108 || mem_d[2] !== 32'hA500_0002) begin
      errors++; $display("[TB] FAIL memstall_word2: got n=%0d %h/%h expected 4 0108/a5000002",
                         mem_a.size(), mem_a[2], mem_d[2]); end
    checks++; if (proto_viol != 0) begin
      errors++; $display("[TB] FAIL memstall_hold: got %0d violations expected 0", proto_viol); end
  endtask

  task automatic test_error();
    bit b, to, ctrl_seen;
    err_en = 1;
    err_addr = 12'h010;
    clear_logs();
    run_copy(24'h001000, 11'd4, 16'h0100, 0, b, to);
    err_en = 0;
    checks++; if (to || err_cnt != 1 || done_cnt != 0) begin
      errors++; $display("[TB] FAIL err_pulse: got err=%0d done=%0d expected 1/0", err_cnt, done_cnt); end
    ctrl_seen = 0;
    foreach (apb_log[i]) if (apb_log[i][43:32] == 12'h008) ctrl_seen = 1;
    checks++; if (ctrl_seen || apb_log.size() != 3) begin
      errors++; $display("[TB] FAIL err_apb: got ctrl=%0b n=%0d expected 0/3", ctrl_seen, apb_log.size()); end
    checks++; if (mem_a.size() != 0 || mem_wait_cycles != 0 || busy_o !== 1'b0) begin
      errors++; $display("[TB] FAIL err_idle: got mem=%0d busy=%b expected 0/0", mem_a.size(), busy_o); end
    clear_logs();
    @(negedge HCLK);
    word_cnt_i = 11'd0; start_i = 1'b1;
    @(negedge HCLK);
    start_i = 1'b0;
    checks++; if (done_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++; $display("[TB] FAIL zero_cnt_pulse: got done=%b busy=%b expected 1/0", done_o, busy_o); end
    repeat (5) @(negedge HCLK);
    checks++; if (done_cnt != 1 || apb_log.size() != 0 || busy_o !== 1'b0) begin
      errors++; $display("[TB] FAIL zero_cnt_quiet: got done=%0d apb=%0d busy=%b expected 1/0/0",
                         done_cnt, apb_log.size(), busy_o); end
  endtask

  task automatic test_reset_mid_pop();
    bit b, to, found;
    stall_cfg = 3;
    clear_logs();
    @(negedge HCLK);
    flash_addr_i = 24'h001000; word_cnt_i = 11'd4; dst_addr_i = 16'h0100; start_i = 1'b1;
    @(negedge HCLK);
    start_i = 1'b0;
    found = 0;
    for (int i = 0; i < 500 && !found; i++) begin
      if (PSEL && PENABLE && PADDR == 12'h020) found = 1;
      else @(negedge HCLK);
    end
    checks++; if (!found) begin
      errors++; $display("[TB] FAIL midpop_reach: got no POP access expected one within 500 cycles"); end
    HRESET = 1'b1;
    @(negedge HCLK);
    checks++; if ({PSEL, PENABLE, mem_req_o, busy_o} !== 4'b0) begin
      errors++; $display("[TB] FAIL midpop_drop: got %b expected 0000", {PSEL, PENABLE, mem_req_o, busy_o}); end
    HRESET = 1'b0;
    stall_cfg = 0;
    clear_logs();
    run_copy(24'h00ABCD, 11'd3, 16'h0200, 0, b, to);
    checks++; if (to || done_cnt != 1 || apb_log.size() != 11) begin
      errors++; $display("[TB] FAIL midpop_rerun: got done=%0d n=%0d expected 1/11", done_cnt, apb_log.size()); end
    checks++; if (apb_log[2] !== {1'b1, 12'h010, 32'h00AB_CD00} || apb_log[3] !== {1'b1, 12'h014, 32'h0060_1808}) begin
      errors++; $display("[TB] FAIL midpop_cfg: got %h %h expected 1010 00abcd00 / 1014 00601808",
                         apb_log[2], apb_log[3]); end
    checks++; if (mem_a.size() != 3 || mem_a[0] !== 16'h0200 || mem_a[2] !== 16'h0208 || mem_d[2] !== 32'hA500_0002) begin
      errors++; $display("[TB] FAIL midpop_mem: got n=%0d %h %h/%h expected 3 0200 0208/a5000002",
                         mem_a.size(), mem_a[0], mem_a[2], mem_d[2]); end
  endtask

  task automatic test_back_to_back();
    bit b, to;
    clear_logs();
    run_copy(24'h000000, 11'd2, 16'hFFFC, 1, b, to);
    checks++; if (to || done_cnt != 1 || apb_log.size() != 9) begin
      errors++; $display("[TB] FAIL b2b_ignore: got done=%0d n=%0d expected 1/9", done_cnt, apb_log.size()); end
    checks++; if (apb_log[3] !== {1'b1, 12'h014, 32'h0040_1808}) begin
      errors++; $display("[TB] FAIL b2b_len: got %h expected 1014 00401808", apb_log[3]); end
    checks++; if (mem_a.size() != 2 || mem_a[0] !== 16'hFFFC || mem_a[1] !== 16'h0000) begin
      errors++; $display("[TB] FAIL b2b_wrap: got n=%0d %h %h expected 2 fffc 0000",
                         mem_a.size(), mem_a[0], mem_a[1]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_apb_stall();
    test_status_poll();
    test_mem_stall();
    test_error();
    test_reset_mid_pop();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
